// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller and its decode peer:
// FSM state encoding, the halt instruction word and the default PC width.
package inst_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam logic [31:0] HALT_INST  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [31:0] word);
        return word == HALT_INST;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, redirect, and the decode handshake.
// master = fetch controller, slave = memory/decode/control environment.
interface inst_fetch_ctrl_if;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        busy;
    logic [31:0] fetch_count;

    modport master (
        input  start, imem_data, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_inst, out_pc, busy, fetch_count
    );

    modport slave (
        output start, imem_data, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_inst, out_pc, busy, fetch_count
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing over a combinational-read memory,
// one-entry registered output stage with valid/ready, redirect and halt handling.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_ctrl_if.master  bus
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] out_pc_q;
    logic [31:0]       out_inst_q;
    logic              out_valid_q;
    logic [31:0]       fetch_count_q;

    logic handshake;
    logic stage_free;
    logic unused_redirect_hi;

    assign handshake  = out_valid_q && bus.out_ready;
    assign stage_free = !out_valid_q || bus.out_ready;

    // Redirect targets wider than the memory wrap silently into it.
    assign unused_redirect_hi = ^bus.redirect_pc[31:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            out_pc_q      <= '0;
            out_inst_q    <= '0;
            out_valid_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (handshake) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            case (state_q)
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        pc_q        <= bus.redirect_pc[ADDR_W-1:0];
                        out_valid_q <= 1'b0;
                    end else if (stage_free) begin
                        out_inst_q  <= bus.imem_data;
                        out_pc_q    <= pc_q;
                        out_valid_q <= 1'b1;
                        pc_q        <= pc_q + ADDR_W'(1);
                        if (is_halt(bus.imem_data)) begin
                            state_q <= ST_HALTED;
                        end
                    end
                end
                default: begin
                    // IDLE and HALTED: only start matters; a halted word drains normally.
                    if (bus.start) begin
                        state_q     <= ST_RUN;
                        pc_q        <= RESET_PC;
                        out_valid_q <= 1'b0;
                        out_inst_q  <= '0;
                        out_pc_q    <= '0;
                    end else if (handshake) begin
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.imem_addr   = {{(32-ADDR_W){1'b0}}, pc_q};
    assign bus.out_pc      = {{(32-ADDR_W){1'b0}}, out_pc_q};
    assign bus.out_inst    = out_inst_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios then random
// start/redirect/ready traffic against a queue-based reference model.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          DEPTH = 256;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] mem [DEPTH];

    inst_fetch_ctrl_if ifc ();

    inst_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    assign ifc.imem_data = mem[ifc.imem_addr[7:0]];

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          m_mode;
    int          m_pc;
    logic [31:0] m_cnt;
    entry_t      stage[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        m_cnt  = '0;
        stage.delete();
    endtask

    task automatic model_cycle(input bit st, input bit rv, input logic [31:0] rpc, input bit rdy);
        entry_t e;
        if (stage.size() != 0 && rdy) begin
            m_cnt++;
            void'(stage.pop_front());
        end
        if (m_mode != M_RUN) begin
            if (st) begin
                m_mode = M_RUN;
                m_pc   = 0;
                stage.delete();
            end
        end else if (rv) begin
            stage.delete();
            m_pc = int'(rpc % DEPTH);
        end else if (stage.size() == 0) begin
            e.inst = mem[m_pc];
            e.pc   = 32'(m_pc);
            stage.push_back(e);
            if (e.inst == HALT) m_mode = M_HALTED;
            m_pc = (m_pc + 1) % DEPTH;
        end
    endtask

    task automatic step(input bit st, input bit rv, input logic [31:0] rpc, input bit rdy);
        ifc.start          = st;
        ifc.redirect_valid = rv;
        ifc.redirect_pc    = rpc;
        ifc.out_ready      = rdy;
        model_cycle(st, rv, rpc, rdy);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(ifc.out_valid), 32'(stage.size() != 0));
        if (stage.size() != 0) begin
            chk("out_inst", ifc.out_inst, stage[0].inst);
            chk("out_pc", ifc.out_pc, stage[0].pc);
        end
        chk("busy", 32'(ifc.busy), 32'(m_mode == M_RUN));
        chk("fetch_count", ifc.fetch_count, m_cnt);
        chk("imem_addr", ifc.imem_addr, 32'(m_pc));
    endtask

    initial begin
        rst_n              = 1'b0;
        ifc.start          = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = '0;
        ifc.out_ready      = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom() & 32'h7FFF_FFFF;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[5] = HALT;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_inst", ifc.out_inst, 32'd0);
        chk("rst_out_pc", ifc.out_pc, 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_fetch_count", ifc.fetch_count, 32'd0);
        chk("rst_imem_addr", ifc.imem_addr, 32'd0);

        // start, first words, stall, release
        step(1, 0, 0, 1);
        chk("start_busy", 32'(ifc.busy), 32'd1);
        step(0, 0, 0, 1);
        chk("first_inst", ifc.out_inst, 32'h11);
        step(0, 0, 0, 1);
        chk("second_inst", ifc.out_inst, 32'h22);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("stall_inst", ifc.out_inst, 32'h22);
            chk("stall_pc", ifc.out_pc, 32'd1);
            chk("stall_addr", ifc.imem_addr, 32'd2);
            chk("stall_count", ifc.fetch_count, 32'd1);
        end
        step(0, 0, 0, 1);
        chk("release_inst", ifc.out_inst, 32'h33);

        // redirect coinciding with a handshake
        step(0, 1, 32'h40, 1);
        chk("redir_count", ifc.fetch_count, 32'd3);
        chk("redir_flush", 32'(ifc.out_valid), 32'd0);
        step(0, 0, 0, 1);
        chk("redir_pc", ifc.out_pc, 32'h40);
        chk("redir_inst", ifc.out_inst, mem[8'h40]);

        // PC wrap
        step(0, 1, 32'hFE, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk("wrap_pc", ifc.out_pc, 32'((8'hFE + i) % 256));
        end

        // truncated redirect, then run into the halt word at 5
        step(0, 1, 32'h103, 1);
        step(0, 0, 0, 1);
        chk("trunc_pc", ifc.out_pc, 32'h3);
        chk("trunc_inst", ifc.out_inst, 32'h44);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("halt_inst", ifc.out_inst, HALT);
        chk("halt_pc", ifc.out_pc, 32'd5);
        chk("halt_busy", 32'(ifc.busy), 32'd0);
        step(0, 1, 32'h20, 1);
        step(0, 0, 0, 1);
        chk("halt_drained", 32'(ifc.out_valid), 32'd0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("restart_pc", ifc.out_pc, 32'd0);
        chk("restart_inst", ifc.out_inst, 32'h11);

        // asynchronous reset mid-run with a pending word
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_count", ifc.fetch_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 24) == 0) ? HALT : ($urandom() & 32'h7FFF_FFFF);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom(),
                 $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
